// File: rtl/lab4_axi_lite_regfile.sv
// AXI4-Lite slave with four 32-bit registers, byte strobes and decoupled AW/W acceptance.
// Optional build macro LAB4_AXI_SLVERR_EN: unmapped slots answer SLVERR instead of OKAY.
module lab4_axi_lite_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      reg_wr_pulse
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef LAB4_AXI_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  logic [3:0][31:0] regs_q, regs_d;
  logic             aw_held_q, aw_held_d;
  logic [2:0]       aw_idx_q, aw_idx_d;
  logic             w_held_q, w_held_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [3:0]       pulse_q, pulse_d;

  logic        aw_hs, w_hs, ar_hs, commit;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] wdata_eff;
  logic [3:0]  wstrb_eff;

  assign S_AXI_AWREADY = ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = ~rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_out       = regs_q;
  assign reg_wr_pulse  = pulse_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    aw_hs     = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs      = S_AXI_WVALID & S_AXI_WREADY;
    ar_hs     = S_AXI_ARVALID & S_AXI_ARREADY;
    // Commit in the handshake cycle itself so AW+W together finish one cycle later.
    commit    = (aw_held_q | aw_hs) & (w_held_q | w_hs);
    wr_idx    = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
    wdata_eff = w_held_q ? wdata_q : S_AXI_WDATA;
    wstrb_eff = w_held_q ? wstrb_q : S_AXI_WSTRB;
    rd_idx    = S_AXI_ARADDR[4:2];

    regs_d    = regs_q;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pulse_d   = '0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (!wr_idx[2]) begin
        bresp_d = RESP_OKAY;
        pulse_d[wr_idx[1:0]] = 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (wstrb_eff[b]) regs_d[wr_idx[1:0]][8*b +: 8] = wdata_eff[8*b +: 8];
        end
      end else begin
        bresp_d = RESP_UNMAPPED;
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Read samples regs_q, so a same-cycle write to that register is not yet visible.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (!rd_idx[2]) begin
        rdata_d = regs_q[rd_idx[1:0]];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_UNMAPPED;
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs_q    <= '0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
    end
  end

endmodule

// File: tb/tb_lab4_axi_lite_regfile.sv
// Directed-vector bench for lab4_axi_lite_regfile; inputs change after posedge, outputs sampled at negedge.
module tb_lab4_axi_lite_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb, pulse;
  logic [1:0]   bresp, rresp;
  logic [127:0] reg_out;

  logic [3:0][31:0] mdl;
  logic [31:0]      rd_d;
  logic [1:0]       rd_r;
  logic [1:0]       exp_err;
  int               vectors = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;

  lab4_axi_lite_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(pulse)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_aw_w(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] eresp, input logic [3:0] epulse);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_w_accept", {awready, wready}, 2'b11);
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("bvalid_lat", bvalid, 1'b1);
    chk("bresp", bresp, eresp);
    chk("wr_pulse", pulse, epulse);
  endtask

  task automatic axi_b_wait();
    int n;
    n = 0;
    while (bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b_done", bvalid, 1'b0);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] eresp, input logic [3:0] epulse);
    axi_aw_w(a, d, s, eresp, epulse);
    axi_b_wait();
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", arready, 1'b1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid_lat", rvalid, 1'b1);
    d = rdata;
    r = rresp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef LAB4_AXI_SLVERR_EN
    exp_err = 2'b10;
`else
    exp_err = 2'b00;
`endif
    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    mdl = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_regs", reg_out, '0);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resp_data", {bresp, rresp, rdata}, '0);
    chk("rst_pulse", pulse, 4'b0000);
    chk("rst_readies", {awready, wready, arready}, 3'b111);

    // Basic write / read-back of all four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(4 * i), 32'(i + 1), 4'hF, 2'b00, 4'(1 << i));
      mdl[i] = 32'(i + 1);
    end
    chk("regs_after_fill", reg_out, mdl);
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(4 * i), rd_d, rd_r);
      chk("rd_data", rd_d, 32'(i + 1));
      chk("rd_resp", rd_r, 2'b00);
    end

    // W three cycles ahead of AW
    @(negedge clk);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);
    #1 wvalid = 1'b0;
    @(negedge clk);
    chk("w_held_wready", wready, 1'b0);
    chk("w_only_no_b", bvalid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    awaddr = 5'h08; awvalid = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0;
    @(negedge clk);
    mdl[2] = 32'hDEADBEEF;
    chk("wfirst_bvalid", bvalid, 1'b1);
    chk("wfirst_reg2", reg_out, mdl);
    chk("wfirst_pulse", pulse, 4'b0100);
    @(negedge clk);
    chk("wfirst_pulse_clr", pulse, 4'b0000);
    chk("wfirst_b_done", bvalid, 1'b0);

    // Byte strobes
    axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 2'b00, 4'b0010);
    axi_write(5'h04, 32'h00000000, 4'b0101, 2'b00, 4'b0010);
    mdl[1] = 32'hFF00FF00;
    chk("strb_reg1", reg_out[63:32], 32'hFF00FF00);
    axi_write(5'h00, 32'hCAFEF00D, 4'b0000, 2'b00, 4'b0001);
    chk("strb0_nochange", reg_out, mdl);

    // B back-pressure with a second write waiting
    bready = 1'b0;
    axi_aw_w(5'h0C, 32'h55, 4'hF, 2'b00, 4'b1000);
    mdl[3] = 32'h55;
    awaddr = 5'h00; wdata = 32'hAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_bvalid", bvalid, 1'b1);
      chk("bp_readies", {awready, wready}, 2'b00);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("bp_b_done", bvalid, 1'b0);
    chk("bp_reg0_untouched", reg_out, mdl);
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    mdl[0] = 32'hAA;
    chk("bp_next_bvalid", bvalid, 1'b1);
    chk("bp_next_reg0", reg_out, mdl);
    axi_b_wait();

    // Unmapped slot
    axi_write(5'h14, 32'h12345678, 4'hF, exp_err, 4'b0000);
    chk("unmapped_wr_regs", reg_out, mdl);
    axi_read(5'h14, rd_d, rd_r);
    chk("unmapped_rd_data", rd_d, 32'h0);
    chk("unmapped_rd_resp", rd_r, exp_err);

    // Read and write to the same register in one cycle
    @(negedge clk);
    araddr = 5'h04; arvalid = 1'b1;
    awaddr = 5'h04; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    #1 arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("rw_same_rdata", rdata, 32'hFF00FF00);
    mdl[1] = 32'h77;
    chk("rw_same_reg1", reg_out, mdl);
    axi_b_wait();

    // Reset with AW held and W outstanding
    @(negedge clk);
    awaddr = 5'h00; awvalid = 1'b1;
    @(posedge clk);
    #1 awvalid = 1'b0;
    @(negedge clk);
    chk("aw_held_awready", awready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_regs", reg_out, '0);
    chk("midrst_bvalid", bvalid, 1'b0);
    chk("midrst_pulse", pulse, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);
    #1 wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_no_commit_b", bvalid, 1'b0);
    chk("midrst_no_commit_regs", reg_out, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
